// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master)
// and the wait-state memory responder (slave).
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Adress;
    logic [31:0] WriteD;
    logic [31:0] Rdata;
    logic        Ready;
    logic        Stall;
    logic        AddrErr;

    modport master (
        output MemRead, MemWrite, Adress, WriteD,
        input  Rdata, Ready, Stall, AddrErr
    );

    modport slave (
        input  MemRead, MemWrite, Adress, WriteD,
        output Rdata, Ready, Stall, AddrErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised, byte-addressed data memory that completes each access
// after WAIT_STATES extra cycles, pulses Ready for one cycle and holds the
// pipeline with Stall while the access is in flight.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Request captured at the accept edge; only these drive a delayed access.
    logic        rd_p0;
    logic        wr_p0;
    logic [31:0] addr_p0;
    logic [31:0] wd_p0;

    // Completion outputs.
    logic [31:0] rdata_p1;
    logic        ready_p1;
    logic        err_p1;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req;
    logic        acc_now;
    logic        acc_rd;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wd;
    logic        acc_err;
    logic [AW-1:0] acc_idx;
    logic        stall;

    assign req = bus.MemRead | bus.MemWrite;

    // Select the operands of the access performed at this edge: live inputs
    // for a zero-wait access straight from IDLE, captured values otherwise.
    always_comb begin
        acc_now  = 1'b0;
        acc_rd   = rd_p0;
        acc_wr   = wr_p0;
        acc_addr = addr_p0;
        acc_wd   = wd_p0;
        if (state == S_IDLE) begin
            acc_rd   = bus.MemRead;
            acc_wr   = bus.MemWrite;
            acc_addr = bus.Adress;
            acc_wd   = bus.WriteD;
            acc_now  = req && (WAIT_STATES == 0);
        end else if (state == S_WAIT) begin
            acc_now  = (cnt == 4'd0);
        end
        acc_err = (acc_rd && acc_wr) || (acc_addr[1:0] != 2'b00) ||
                  ({1'b0, acc_addr} >= LIMIT);
        acc_idx = acc_addr[AW+1:2];
    end

    // Stall holds the pipeline from request through the last wait cycle.
    always_comb begin
        stall = 1'b0;
        case (state)
            S_IDLE:  stall = req;
            S_WAIT:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // ---- stage 0: capture the request at the accept edge ----
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            rd_p0   <= bus.MemRead;
            wr_p0   <= bus.MemWrite;
            addr_p0 <= bus.Adress;
            wd_p0   <= bus.WriteD;
        end
    end

    // Array write; gated by rst_n so a reset can never commit a store.
    always_ff @(posedge clk) begin
        if (rst_n && acc_now && acc_wr && !acc_err)
            mem[acc_idx] <= acc_wd;
    end

    // ---- stage 1: sequencing and registered completion ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ready_p1 <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= 32'd0;
        end else begin
            ready_p1 <= 1'b0;
            err_p1   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && (WAIT_STATES != 0)) begin
                        cnt   <= 4'(WAIT_STATES - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
            if (acc_now) begin
                state    <= S_DONE;
                ready_p1 <= 1'b1;
                if (acc_err) begin
                    err_p1   <= 1'b1;
                    rdata_p1 <= 32'd0;
                end else if (acc_rd) begin
                    rdata_p1 <= mem[acc_idx];
                end
            end
        end
    end

    assign bus.Rdata   = rdata_p1;
    assign bus.Ready   = ready_p1;
    assign bus.AddrErr = err_p1;
    assign bus.Stall   = stall;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states.
module tb_data_mem_responder;
    logic clk;
    logic rst_n;
    logic sel;   // 0: WAIT_STATES=2 instance, 1: WAIT_STATES=0 instance
    int   checks;
    int   failures;

    data_mem_responder_if b2 ();
    data_mem_responder_if b0 ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave)
    );

    logic        stall_o, ready_o, err_o;
    logic [31:0] rdata_o;
    assign stall_o = sel ? b0.Stall   : b2.Stall;
    assign ready_o = sel ? b0.Ready   : b2.Ready;
    assign err_o   = sel ? b0.AddrErr : b2.AddrErr;
    assign rdata_o = sel ? b0.Rdata   : b2.Rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        b0.MemRead = 1'b0; b0.MemWrite = 1'b0;
        b2.MemRead = 1'b0; b2.MemWrite = 1'b0;
        if (sel) begin
            b0.MemRead = r; b0.MemWrite = w; b0.Adress = a; b0.WriteD = d;
        end else begin
            b2.MemRead = r; b2.MemWrite = w; b2.Adress = a; b2.WriteD = d;
        end
    endtask

    // One access; optionally changes Adress/WriteD one cycle after acceptance.
    task automatic do_access(input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic chg, input logic [31:0] ca, input logic [31:0] cd,
                             output int stalls, output logic rdy, output logic aerr,
                             output logic stall_done, output logic [31:0] rd,
                             output logic busy_after);
        @(negedge clk);
        set_req(r, w, a, d);
        #1;
        stalls = 0;
        while (stall_o === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
            if (chg && stalls == 1) set_req(r, w, ca, cd);
        end
        rdy        = ready_o;
        aerr       = err_o;
        stall_done = stall_o;
        rd         = rdata_o;
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        busy_after = ready_o | err_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({b2.Rdata, b2.Ready, b2.Stall, b2.AddrErr} !== 35'd0) begin
                failures++;
                $display("FAIL reset_idle_ws2 cyc=%0d got rdata=%h rdy=%b stall=%b err=%b expected all 0",
                         i, b2.Rdata, b2.Ready, b2.Stall, b2.AddrErr);
            end
            checks++;
            if ({b0.Rdata, b0.Ready, b0.Stall, b0.AddrErr} !== 35'd0) begin
                failures++;
                $display("FAIL reset_idle_ws0 cyc=%0d got rdata=%h rdy=%b stall=%b err=%b expected all 0",
                         i, b0.Rdata, b0.Ready, b0.Stall, b0.AddrErr);
            end
        end
    endtask

    task automatic expect_ok(input string name, input int stalls, input int exp_stalls,
                             input logic rdy, input logic aerr, input logic sd,
                             input logic ba, input logic [31:0] rd, input logic [31:0] exp_rd);
        checks++;
        if (stalls != exp_stalls || rdy !== 1'b1 || aerr !== 1'b0 || sd !== 1'b0 || ba !== 1'b0) begin
            failures++;
            $display("FAIL %s timing got stalls=%0d rdy=%b err=%b stall_done=%b pulse_after=%b expected stalls=%0d rdy=1 err=0 stall_done=0 pulse_after=0",
                     name, stalls, rdy, aerr, sd, ba, exp_stalls);
        end
        checks++;
        if (rd !== exp_rd) begin
            failures++;
            $display("FAIL %s rdata got %h expected %h", name, rd, exp_rd);
        end
    endtask

    task automatic expect_err(input string name, input int stalls, input logic rdy,
                              input logic aerr, input logic [31:0] rd);
        checks++;
        if (stalls != 3 || rdy !== 1'b1 || aerr !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL %s got stalls=%0d rdy=%b err=%b rdata=%h expected stalls=3 rdy=1 err=1 rdata=0",
                     name, stalls, rdy, aerr, rd);
        end
    endtask

    task automatic test_write_read();
        int s; logic rdy, ae, sd, ba; logic [31:0] rd;
        sel = 1'b0;
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("ws2_write_0x10", s, 3, rdy, ae, sd, ba, rd, 32'd0);
        do_access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("ws2_read_0x10", s, 3, rdy, ae, sd, ba, rd, 32'hDEADBEEF);
        // A write must leave Rdata holding the last read value.
        do_access(1'b0, 1'b1, 32'h14, 32'h11111111, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("ws2_write_holds_rdata", s, 3, rdy, ae, sd, ba, rd, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'h14, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("ws2_read_0x14", s, 3, rdy, ae, sd, ba, rd, 32'h11111111);
    endtask

    task automatic test_errors();
        int s; logic rdy, ae, sd, ba; logic [31:0] rd;
        sel = 1'b0;
        do_access(1'b1, 1'b0, 32'h11, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_err("err_misaligned_read", s, rdy, ae, rd);
        do_access(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("preload_0x0", s, 3, rdy, ae, sd, ba, rd, 32'd0);
        do_access(1'b0, 1'b1, 32'h400, 32'h0BADBAD0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_err("err_out_of_range_write", s, rdy, ae, rd);
        do_access(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("read_0x0_after_bad_write", s, 3, rdy, ae, sd, ba, rd, 32'hCAFEF00D);
        do_access(1'b1, 1'b1, 32'h0, 32'h77777777, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_err("err_read_and_write", s, rdy, ae, rd);
        do_access(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("read_0x0_after_both", s, 3, rdy, ae, sd, ba, rd, 32'hCAFEF00D);
    endtask

    task automatic test_input_change();
        int s; logic rdy, ae, sd, ba; logic [31:0] rd;
        sel = 1'b0;
        do_access(1'b0, 1'b1, 32'h24, 32'h55, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        do_access(1'b0, 1'b1, 32'h20, 32'h1, 1'b1, 32'h24, 32'h2, s, rdy, ae, sd, rd, ba);
        checks++;
        if (s != 3 || rdy !== 1'b1 || ae !== 1'b0) begin
            failures++;
            $display("FAIL chg_write_timing got stalls=%0d rdy=%b err=%b expected 3 1 0", s, rdy, ae);
        end
        do_access(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("chg_read_0x20", s, 3, rdy, ae, sd, ba, rd, 32'h1);
        do_access(1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("chg_read_0x24", s, 3, rdy, ae, sd, ba, rd, 32'h55);
    endtask

    task automatic test_reset_mid();
        int s; logic rdy, ae, sd, ba; logic [31:0] rd;
        sel = 1'b0;
        do_access(1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'h8, 32'hAAAA5555);
        @(negedge clk);   // accepted, now waiting
        #1;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet cyc=%0d got rdy=%b stall=%b err=%b expected 0 0 0",
                         i, ready_o, stall_o, err_o);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_ready cyc=%0d got rdy=%b expected 0", i, ready_o);
            end
        end
        do_access(1'b1, 1'b0, 32'h8, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("reset_mid_read_0x8", s, 3, rdy, ae, sd, ba, rd, 32'h0);
    endtask

    task automatic test_ws0();
        int s; logic rdy, ae, sd, ba; logic [31:0] rd;
        sel = 1'b1;
        do_access(1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("ws0_write_0x0", s, 1, rdy, ae, sd, ba, rd, 32'd0);
        do_access(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        expect_ok("ws0_read_0x0", s, 1, rdy, ae, sd, ba, rd, 32'h12345678);
        do_access(1'b1, 1'b0, 32'h3FD, 32'd0, 1'b0, 32'd0, 32'd0, s, rdy, ae, sd, rd, ba);
        checks++;
        if (s != 1 || rdy !== 1'b1 || ae !== 1'b1 || rd !== 32'd0) begin
            failures++;
            $display("FAIL ws0_err_misaligned got stalls=%0d rdy=%b err=%b rdata=%h expected 1 1 1 0",
                     s, rdy, ae, rd);
        end
        sel = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        b0.MemRead = 1'b0; b0.MemWrite = 1'b0; b0.Adress = 32'd0; b0.WriteD = 32'd0;
        b2.MemRead = 1'b0; b2.MemWrite = 1'b0; b2.Adress = 32'd0; b2.WriteD = 32'd0;
        test_reset();
        test_write_read();
        test_errors();
        test_input_change();
        test_reset_mid();
        test_ws0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the pipeline's data-memory interface: the MEM stage drives MemRead/MemWrite/Adress/WriteD, and this block completes the access after a programmable number of wait states.
- Returns Rdata with a one-cycle Ready pulse.
- Holds the pipeline with Stall while an access is in flight.
- Replaces the zero-latency combinational data memory; word-organised, byte-addressed.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-4.
WAIT_STATES, 2, extra cycles between request acceptance and completion (0..15).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset; asynchronous, active-low.
MemRead  in  1  read request, held stable by the requester while Stall=1.
MemWrite  in  1  write request, held stable by the requester while Stall=1.
Adress  in  32  byte address of the access.
WriteD  in  32  store data.
Rdata  out  32  read data; registered.
Ready  out  1  one-cycle pulse: access complete.
Stall  out  1  pipeline hold; combinational from state and request inputs.
AddrErr  out  1  one-cycle pulse with Ready: access rejected.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; counter is 0.
  - Rdata=0, Ready=0, AddrErr=0, Stall=0.
  - The memory array is not cleared.
- States: IDLE, WAIT, DONE.
- req = MemRead | MemWrite.
- IDLE:
  - Stall = req.
  - On a clock edge with req=1, capture op, Adress and WriteD.
  - WAIT_STATES>0: load counter with WAIT_STATES-1 and go to WAIT.
  - WAIT_STATES=0: perform the access and go to DONE.
  - req=0: stay in IDLE.
- WAIT:
  - Stall=1.
  - Counter>0: decrement.
  - Counter=0: perform the access at this edge and go to DONE.
- DONE:
  - Stall=0, Ready=1 for exactly one cycle.
  - Unconditionally return to IDLE; the pipeline register advances at this edge.
  - A new request is evaluated in the following IDLE cycle.
- Latency: accept edge to Ready = WAIT_STATES+1 cycles. Total Stall cycles per access = WAIT_STATES+1.
- Access uses only the captured values; input changes after capture are ignored.
  - Write: mem[Adress[31:2]] <= WriteD; Rdata unchanged.
  - Read: Rdata <= mem[Adress[31:2]]; Rdata holds that value until the next read or error completion.
- Error: the captured request is rejected when any of these holds:
  - MemRead and MemWrite both 1.
  - Adress[1:0] != 0.
  - Adress >= 4*DEPTH_WORDS.
- A rejected request still walks IDLE->WAIT->DONE with normal timing, but in DONE:
  - AddrErr=1 together with Ready=1.
  - No array write occurs.
  - Rdata <= 0.
- Reset mid-access (in WAIT) aborts the access: no write is committed, and Ready does not pulse.
- Read-after-write to the same address in the next access returns the new data.
- Ready and AddrErr are never asserted outside DONE. Stall is never asserted in DONE.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release, no requests → Rdata=0, Ready/Stall/AddrErr=0 for 10 cycles.
- Write then read, WAIT_STATES=2:
  - MemWrite=1, Adress=0x10, WriteD=0xDEADBEEF → Stall high for 3 cycles; Ready pulses 3 cycles after the accept edge.
  - Then MemRead=1, Adress=0x10 → Ready pulse with Rdata=0xDEADBEEF.
- WAIT_STATES=0: read of 0x0 after write of 0x12345678 → Stall high 1 cycle, Ready the next cycle, Rdata=0x12345678.
- Errors:
  - Read at 0x11 → Ready+AddrErr, Rdata=0.
  - Write at 0x400 (DEPTH_WORDS=256) → Ready+AddrErr; a subsequent read of 0x0 is unchanged.
  - MemRead=MemWrite=1 → AddrErr.
- Input change during WAIT: after acceptance of a write to 0x20 with WriteD=0x1, change WriteD to 0x2 and Adress to 0x24 → mem[0x20]=0x1, mem[0x24] untouched.
- Reset mid-access: write 0xAAAA5555 to 0x8, assert rst_n=0 during WAIT → no Ready; after release, a read of 0x8 returns its prior value 0x0 (preloaded by an earlier write).
